// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with a fixed number of wait states.
// Accepts one load/store at a time and answers on a registered response channel.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [Words];

  logic                  accept;
  logic                  commit;
  logic                  use_live;
  logic                  c_wr;
  logic [31:0]           c_addr;
  logic [31:0]           c_wdata;
  logic [3:0]            c_be;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;

  assign accept = (state_q == StIdle) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so operands come straight
  // from the request inputs instead of the latched copy.
  always_comb begin
    use_live = (state_q == StIdle);
    c_wr     = use_live ? req_write : wr_q;
    c_addr   = use_live ? req_addr  : addr_q;
    c_wdata  = use_live ? req_wdata : wdata_q;
    c_be     = use_live ? req_be    : be_q;
    c_err    = (c_addr[1:0] != 2'b00) || ((c_addr[31:2] >> DEPTH_LOG2) != 30'd0);
    c_idx    = c_addr[DEPTH_LOG2+1:2];
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = c_err;
      rdata_d = (!c_wr && !c_err) ? mem[c_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Array has no reset; rst still blocks a commit so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (commit && c_wr && !c_err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_be = '0;
  logic        a_resp_valid, a_resp_ready = 1'b0, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(1'b1),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; lat counts edges from the accept edge inclusive.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!a_resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    a_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    a_resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    @(negedge clk);
    a_req_write = w;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    wait_resp(lat);
    rdata = a_resp_rdata;
    err   = a_resp_err;
    finish_resp();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  logic [31:0] b_addr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
  logic [31:0] b_wdat [4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0, 32'h0};
  logic        b_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] b_exp  [4] = '{32'h0, 32'h0, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_rdata", a_resp_rdata, 32'd0);
    check("rst_err", 32'(a_resp_err), 32'd0);
    check("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Store then load
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("st_lat", 32'(lat), 32'd3);
    check("st_rdata", rd, 32'd0);
    check("st_err", 32'(er), 32'd0);
    check("idle_after_resp", 32'(a_req_ready), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld_lat", 32'(lat), 32'd3);
    check("ld_rdata", rd, 32'hDEAD_BEEF);
    check("ld_err", 32'(er), 32'd0);

    // Byte enables
    do_req(1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("be_rdata", rd, 32'h11BB_33DD);

    // Errors
    do_req(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    check("misal_err", 32'(er), 32'd1);
    check("misal_rdata", rd, 32'd0);
    do_req(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("oor_nochange", rd, 32'hCAFE_F00D);
    check("oor_ld_err", 32'(er), 32'd0);

    // Backpressure with req_valid held
    @(negedge clk);
    a_req_write = 1'b0;
    a_req_addr  = 32'h10;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_addr = 32'h20;
    wait_resp(lat);
    check("bp_lat", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(a_resp_valid), 32'd1);
      check("bp_rdata", a_resp_rdata, 32'hDEAD_BEEF);
      check("bp_req_ready", 32'(a_req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp_still_valid", 32'(a_resp_valid), 32'd1);
    finish_resp();
    check("bp_idle_ready", 32'(a_req_ready), 32'd1);
    check("bp_idle_valid", 32'(a_resp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_second_accept", 32'(a_req_ready), 32'd0);
    a_req_valid = 1'b0;
    wait_resp(lat);
    check("bp_second_lat", 32'(lat), 32'd3);
    check("bp_second_rdata", a_resp_rdata, 32'h11BB_33DD);
    finish_resp();

    // Reset during WAIT
    do_req(1'b1, 32'h40, 32'h1234_5678, 4'hF, rd, er, lat);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    check("pre_rst_ld", rd, 32'h1234_5678);
    @(negedge clk);
    a_req_write = 1'b1;
    a_req_addr  = 32'h40;
    a_req_wdata = 32'h55;
    a_req_be    = 4'hF;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    check("in_wait_ready", 32'(a_req_ready), 32'd0);
    check("in_wait_rdata", a_resp_rdata, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_req_ready", 32'(a_req_ready), 32'd1);
    check("async_resp_valid", 32'(a_resp_valid), 32'd0);
    check("async_rdata", a_resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    check("abort_no_store", rd, 32'h1234_5678);
    do_req(1'b1, 32'h40, 32'h0, 4'hF, rd, er, lat);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    check("post_rst_ld", rd, 32'h0);

    // Zero wait states, back-to-back
    @(negedge clk);
    b_req_write = b_wr[0];
    b_req_addr  = b_addr[0];
    b_req_wdata = b_wdat[0];
    b_req_be    = 4'hF;
    b_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("z_resp_valid", 32'(b_resp_valid), 32'd1);
      check("z_req_ready_lo", 32'(b_req_ready), 32'd0);
      check("z_rdata", b_resp_rdata, b_exp[i]);
      check("z_err", 32'(b_resp_err), 32'd0);
      @(posedge clk);
      #1;
      check("z_idle_ready", 32'(b_req_ready), 32'd1);
      check("z_idle_valid", 32'(b_resp_valid), 32'd0);
      if (i < 3) begin
        b_req_write = b_wr[i+1];
        b_req_addr  = b_addr[i+1];
        b_req_wdata = b_wdat[i+1];
      end else begin
        b_req_valid = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
